// File: rtl/cpu16_pkg.sv
// cpu16_pkg: shared widths, divider state encoding and iteration count
package cpu16_pkg;
  localparam int WIDTH = 16;
  localparam int DIV_ITER = WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
endpackage

// File: rtl/alu1bit.sv
// alu1bit: one-bit add/subtract slice with operand-a enable, b inversion and reset gating
module alu1bit (
  input  logic reset,
  input  logic aen,
  input  logic binv,
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic ae, be;
  always_comb begin
    ae = a & aen;
    be = b ^ binv;
    sum = !reset & (ae ^ be ^ cin);
    cout = !reset & ((ae & be) | (cin & (ae ^ be)));
  end
endmodule

// File: rtl/sub16_chain.sv
// sub16_chain: ripple a - b on alu1bit slices; cout=1 means no borrow
module sub16_chain import cpu16_pkg::*; #(
  parameter int W = WIDTH + 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         cout
);
  logic [W:0] c;
  assign c[0] = 1'b1;
  for (genvar g = 0; g < W; g++) begin : g_slice
    alu1bit u_slice (
      .reset(1'b0),
      .aen  (1'b1),
      .binv (1'b1),
      .a    (a[g]),
      .b    (b[g]),
      .cin  (c[g]),
      .sum  (diff[g]),
      .cout (c[g+1])
    );
  end
  assign cout = c[W];
endmodule

// File: rtl/div16_seq.sv
// div16_seq: sequential restoring unsigned divider, one quotient bit per clock
module div16_seq #(
  parameter int WIDTH = cpu16_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  import cpu16_pkg::*;
  localparam int CW = $clog2(WIDTH) + 1;
  div_state_t state, next;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] p, q, dvs, p_n, q_n;
  logic [WIDTH:0] ps, t;
  logic cout, accept, fit, last, zero;
  assign ps = {p, q[WIDTH-1]};
  sub16_chain #(.W(WIDTH + 1)) u_sub (
    .a   (ps),
    .b   ({1'b0, dvs}),
    .diff(t),
    .cout(cout)
  );
  always_comb begin
    accept = start && state != RUN;
    zero = divisor == '0;
    // the top difference bit must also be clear for the trial to fit in WIDTH bits
    fit = cout && !t[WIDTH];
    last = cnt == CW'(WIDTH - 1);
    p_n = fit ? t[WIDTH-1:0] : ps[WIDTH-1:0];
    q_n = {q[WIDTH-2:0], fit};
    next = accept ? (zero ? DONE : RUN) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) state <= !reset ? IDLE : next;
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
      p <= '0;
      q <= '0;
      dvs <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      p <= '0;
      q <= dividend;
      dvs <= divisor;
      div_by_zero <= zero;
      if (zero) begin
        quotient <= '1;
        remainder <= dividend;
      end
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      p <= p_n;
      q <= q_n;
      if (last) begin
        quotient <= q_n;
        remainder <= p_n;
      end
    end
  end
endmodule

// File: tb/tb_div16_seq.sv
// tb_div16_seq: directed checks of div16_seq latency, results and handshake corners
module tb_div16_seq;
  logic clk = 0, reset = 0, start = 0;
  logic [15:0] dividend = 0, divisor = 0;
  logic busy, done, div_by_zero;
  logic [15:0] quotient, remainder;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  div16_seq dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_done(output int n);
    n = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (busy) n++;
      @(negedge clk);
    end
  endtask
  task automatic op(input string tag, input logic [15:0] dd, input logic [15:0] dv,
                    input logic [15:0] eq, input logic [15:0] er, input logic ez, input int poke);
    int n = 0;
    int extra = 0;
    @(negedge clk);
    dividend = dd; divisor = dv; start = 1;
    @(negedge clk);
    start = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (busy) n++;
      start = poke != 0 && n == poke;
      if (start) begin dividend = 50; divisor = 5; end
      @(negedge clk);
    end
    start = 0;
    chk({tag, " busy_cycles"}, n, ez ? 0 : 16);
    chk({tag, " done"}, done, 1);
    chk({tag, " busy_at_done"}, busy, 0);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_by_zero"}, div_by_zero, ez);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk({tag, " extra_done"}, extra, 0);
  endtask
  initial begin
    int n;
    int cnt;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset outputs", {quotient, remainder}, 0);
    chk("reset dbz", div_by_zero, 0);
    reset = 1;
    op("100/7", 100, 7, 14, 2, 0, 0);
    op("ffff/1", 16'hffff, 1, 16'hffff, 0, 0, 0);
    op("ffff/ffff", 16'hffff, 16'hffff, 1, 0, 0, 0);
    op("3/10", 3, 10, 0, 3, 0, 0);
    op("div0", 16'h1234, 0, 16'hffff, 16'h1234, 1, 0);
    op("start_busy", 100, 7, 14, 2, 0, 5);
    // reset in the middle of a run
    @(negedge clk);
    dividend = 100; divisor = 7; start = 1;
    @(negedge clk);
    start = 0;
    repeat (7) @(negedge clk);
    chk("mid busy", busy, 1);
    reset = 0;
    @(negedge clk);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort outputs", {quotient, remainder}, 0);
    chk("abort dbz", div_by_zero, 0);
    reset = 1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("abort no_done", cnt, 0);
    op("9/2", 9, 2, 4, 1, 0, 0);
    // back-to-back: start held through the DONE cycle
    @(negedge clk);
    dividend = 100; divisor = 7; start = 1;
    @(negedge clk);
    start = 0;
    wait_done(n);
    chk("b2b first busy_cycles", n, 16);
    chk("b2b first done", done, 1);
    chk("b2b first quotient", quotient, 14);
    dividend = 1000; divisor = 33; start = 1;
    @(negedge clk);
    start = 0;
    chk("b2b second accept busy", busy, 1);
    chk("b2b second accept done", done, 0);
    wait_done(n);
    chk("b2b second busy_cycles", n, 16);
    chk("b2b second done", done, 1);
    chk("b2b second quotient", quotient, 30);
    chk("b2b second remainder", remainder, 10);
    chk("b2b second dbz", div_by_zero, 0);
    @(negedge clk);
    chk("b2b second done_drop", done, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
